// File: rtl/mrt_pkg.sv
// ---- mrt_pkg ---------------------------------------------------------------
// Shared types and constants for the station-graph BFS controller. rev 1.0
`default_nettype none

package mrt_pkg;
  localparam int N_STA   = 16;
  localparam int SRC_STA = 0;
  localparam int DST_STA = 15;

  typedef logic [3:0]       sta_t;
  typedef logic [N_STA-1:0] mask_t;
  typedef mask_t [N_STA-1:0] adj_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SEARCH = 2'd2,
    OUT    = 2'd3
  } state_t;

  localparam mask_t SRC_ONEHOT = mask_t'(1) << SRC_STA;
endpackage

`default_nettype wire

// File: rtl/mrt_frontier_expand.sv
// ---- mrt_frontier_expand ---------------------------------------------------
// One BFS level: union of neighbour rows of the frontier, minus visited. rev 1.0
`default_nettype none

module mrt_frontier_expand
  import mrt_pkg::*;
(
  input  adj_t  adj,
  input  mask_t frontier,
  input  mask_t visited,
  output mask_t next_mask
);

  mask_t reached;

  always_comb begin
    reached = '0;
    for (int i = 0; i < N_STA; i++) begin
      if (frontier[i]) reached = reached | adj[i];
    end
    next_mask = reached & ~visited;
  end

endmodule

`default_nettype wire

// File: rtl/mrt_bfs_ctrl.sv
// ---- mrt_bfs_ctrl ----------------------------------------------------------
// Edge-stream capture plus level-synchronous BFS hop count, 0 -> 15. rev 1.0
`default_nettype none

module mrt_bfs_ctrl
  import mrt_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] source,
  input  logic [3:0] destination,
  output logic       out_valid,
  output logic [3:0] cost
);

  state_t state, state_nxt;
  adj_t   adj;
  mask_t  visited, frontier, nxt_mask;
  sta_t   level;
  logic   done, edge_wr, out_valid_d;
  sta_t   cost_d;

  mrt_frontier_expand u_expand (
    .adj       (adj),
    .frontier  (frontier),
    .visited   (visited),
    .next_mask (nxt_mask)
  );

  assign done    = (state == SEARCH) && (nxt_mask[DST_STA] || (nxt_mask == '0));
  assign edge_wr = in_valid && ((state == IDLE) || (state == LOAD)) && (source != destination);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = LOAD;
      LOAD:    if (!in_valid) state_nxt = SEARCH;
      SEARCH:  if (done)      state_nxt = OUT;
      OUT:                    state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid_d = done;
    cost_d      = (done && nxt_mask[DST_STA]) ? level + 4'd1 : 4'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      cost      <= '0;
    end else begin
      out_valid <= out_valid_d;
      cost      <= cost_d;
    end
  end

  // Leaving OUT wipes the graph so IDLE always starts from an empty adjacency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adj      <= '0;
      visited  <= '0;
      frontier <= '0;
      level    <= '0;
    end else if (state == OUT) begin
      adj      <= '0;
      visited  <= '0;
      frontier <= '0;
      level    <= '0;
    end else begin
      if (edge_wr) begin
        adj[source][destination] <= 1'b1;
        adj[destination][source] <= 1'b1;
      end
      if ((state == LOAD) && !in_valid) begin
        visited  <= SRC_ONEHOT;
        frontier <= SRC_ONEHOT;
        level    <= '0;
      end else if (state == SEARCH) begin
        visited  <= visited | nxt_mask;
        frontier <= nxt_mask;
        level    <= level + 4'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mrt_bfs_ctrl.sv
// ---- tb_mrt_bfs_ctrl -------------------------------------------------------
// Directed self-checking bench for mrt_bfs_ctrl. rev 1.0
`default_nettype none

module tb_mrt_bfs_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] source;
  logic [3:0] destination;
  logic       out_valid;
  logic [3:0] cost;

  int total = 0;
  int bad   = 0;

  mrt_bfs_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .source      (source),
    .destination (destination),
    .out_valid   (out_valid),
    .cost        (cost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives one edge for exactly one cycle.
  task automatic add_edge(input int s, input int d);
    in_valid    = 1'b1;
    source      = 4'(s);
    destination = 4'(d);
    @(negedge clk);
  endtask

  // Ends the burst, finds the pulse edge Pk, checks cost and the drop on Pk+1.
  task automatic finish(input string tag, input int exp_cost, input int exp_k);
    int found_k;
    logic [3:0] got_cost;
    in_valid    = 1'b0;
    source      = '0;
    destination = '0;
    found_k     = 0;
    got_cost    = '0;
    @(negedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        found_k  = k;
        got_cost = cost;
        break;
      end
    end
    chk({tag, "_pulse_k"}, 8'(found_k), 8'(exp_k));
    chk({tag, "_cost"}, 8'(got_cost), 8'(exp_cost));
    @(negedge clk);
    chk({tag, "_ov_drop"}, 8'(out_valid), 8'd0);
    chk({tag, "_cost_drop"}, 8'(cost), 8'd0);
  endtask

  initial begin
    int seen;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    source      = '0;
    destination = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_ov", 8'(out_valid), 8'd0);
    chk("reset_cost", 8'(cost), 8'd0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    chk("idle_no_pulse", 8'(seen), 8'd0);

    // Single direct edge
    add_edge(0, 15);
    finish("single", 1, 1);

    // Full chain, reverse order, swapped endpoints on odd edges
    for (int i = 0; i < 15; i++) begin
      if (i % 2 == 1) add_edge(15 - i, 14 - i);
      else            add_edge(14 - i, 15 - i);
    end
    finish("chain", 15, 15);

    // Self-loop and duplicate mixed in
    add_edge(0, 1);
    add_edge(1, 2);
    add_edge(2, 15);
    add_edge(15, 0);
    add_edge(3, 3);
    add_edge(1, 2);
    finish("loopdup", 1, 1);

    // Disconnected, then back-to-back pattern
    add_edge(0, 1);
    add_edge(2, 15);
    finish("disc", 0, 2);
    add_edge(2, 15);
    add_edge(0, 2);
    finish("b2b", 2, 2);

    // Async reset while out_valid is high
    add_edge(0, 15);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_async_ov", 8'(out_valid), 8'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_ov", 8'(out_valid), 8'd0);
    chk("async_cost", 8'(cost), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset right after P1 of the chain pattern
    for (int i = 0; i < 15; i++) begin
      if (i % 2 == 1) add_edge(15 - i, 14 - i);
      else            add_edge(14 - i, 15 - i);
    end
    in_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen++;
    end
    chk("abort_no_pulse", 8'(seen), 8'd0);

    // Stale chain adjacency would make this reachable
    add_edge(0, 1);
    finish("post_rst_stale", 0, 2);
    add_edge(0, 15);
    finish("post_rst", 1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mrt_bfs_ctrl.md
# mrt_bfs_ctrl

Search controller for the station-graph cost engine. It captures an undirected edge stream (`source`/`destination` pairs under `in_valid`) into a 16×16 adjacency register. It then runs a level-synchronous breadth-first search from station 0 to station 15, one level per cycle, and returns the minimum hop count as a one-cycle `out_valid` pulse. It is the top-level block driven directly by the lab testbench.

## Interface
- `N_STA`, 16, number of stations; station IDs are 0..N_STA-1.
- `SRC_STA`, 0, search origin station.
- `DST_STA`, 15, search target station.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  high for one cycle per edge, contiguous burst per pattern.
- `source`  in  4  edge endpoint A; valid only while `in_valid`=1.
- `destination`  in  4  edge endpoint B; valid only while `in_valid`=1.
- `out_valid`  out  1  result strobe, high exactly one cycle per pattern.
- `cost`  out  4  hop count 0→15; 0 = unreachable; forced to 0 whenever `out_valid`=0.

## Operation
- FSM states: IDLE, LOAD, SEARCH, OUT.
- IDLE:
  - Adjacency is all-zero.
  - Edge with `in_valid`=1 → store the edge, go to LOAD.
- LOAD:
  - Each edge with `in_valid`=1 sets `adj[s][d]` and `adj[d][s]`.
  - Self-loops (s==d) are ignored. Duplicate edges are harmless.
  - Edge with `in_valid`=0 → go to SEARCH. On that same edge: `visited`=`frontier`=one-hot(SRC_STA), `level`=0.
- SEARCH, each cycle:
  - `next` = OR of `adj` rows selected by `frontier`, AND NOT `visited`.
  - `visited` |= `next`; `frontier` = `next`; `level`+1.
  - `next[DST_STA]`=1 → latch `cost`=`level`+1, go to OUT.
  - `next`==0 → latch `cost`=0, go to OUT.
- OUT:
  - `out_valid`=1 for this one cycle.
  - Adjacency, `visited`, `frontier` and `level` are cleared.
  - Next edge → IDLE; `out_valid`=0 and `cost`=0 from then on.
- Arithmetic: `level` is 4 bits and cannot exceed 15, because at most 15 new stations can be discovered. No saturation logic is needed.
- `in_valid` during SEARCH or OUT is a protocol violation. It is ignored and its edges are discarded.
- An empty pattern (no `in_valid` cycles) never leaves IDLE.

## Timing
- Reset value of every output and register is 0; state = IDLE. This holds immediately on `rst_n` falling, independent of `clk`.
- Reset mid-LOAD/SEARCH/OUT:
  - Abort with no `out_valid` pulse.
  - Adjacency is cleared.
  - The next pattern behaves as if it were the first.
- Latency, with P0 = the first rising edge sampling `in_valid`=0 after a burst:
  - `out_valid` rises on edge Pk, where k = hop count (1..15).
  - For unreachable, k = BFS depth at which the frontier empties (1..15).
  - Worst case is 15 cycles.
- The next burst may begin on the cycle immediately after `out_valid` (the state is IDLE by then).
- `out_valid` and `cost` are registered outputs with no combinational path from inputs.

## Structure
- Package `mrt_pkg`:
  - `N_STA`, `SRC_STA`, `DST_STA` localparams.
  - `sta_t` (4-bit) and `mask_t` (N_STA-bit) typedefs.
  - `state_t` enum {IDLE, LOAD, SEARCH, OUT}.
- Sub-module `mrt_frontier_expand`: purely combinational, inputs (`adj`, `frontier`, `visited`) → `next`. It is a reduction OR over 16 rows and is unit-tested separately.
- Top module holds the FSM, the adjacency register file, the masks, the level counter and the output registers.

## Test plan
- Reset with `in_valid`=0 → `out_valid`=0 and `cost`=0 right after `rst_n` rises; no pulse for 20 cycles.
- Single edge (0,15) → `cost`=1; `out_valid` high on P1 only, low on P2.
- Chain 14-15, 13-14, …, 0-1 (15 edges, reverse order, endpoints swapped on odd edges) → `cost`=15, pulse at P15.
- Edges 0-1, 1-2, 2-15, 15-0, 3-3, 1-2 (duplicate) → `cost`=1; self-loop and duplicate cause no error.
- Disconnected: edges 0-1, 2-15 → `cost`=0, pulse at P2. Then next pattern 2-15, 0-2 immediately after → `cost`=2, proving adjacency was cleared.
- Assert `rst_n`=0 at P1 of the chain pattern → no pulse. Then edge (0,15) → `cost`=1, no stale adjacency from the chain.
